// File: rtl/mc_if.sv
// ----------------------------------------------------------------------------
// mc_if: control bundle between the multicycle MIPS control unit and its
// datapath.
//   master (control unit): takes op/funct/zero and drives the mux selects,
//                          write strobes, alucontrol, illegal and dbg_state.
//   slave  (datapath)    : the mirror image.
// There is no valid/ready handshake here. Every signal is a level sampled on
// the rising edge of the shared clock. op/funct come from the held
// instruction register, and zero comes straight from the ALU.
// ----------------------------------------------------------------------------
interface mc_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] dbg_state;

   modport master (
      input  op, funct, zero,
      output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal, dbg_state
   );

   modport slave (
      output op, funct, zero,
      input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, alucontrol, illegal, dbg_state
   );
endinterface

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller: multicycle MIPS control unit.
// It steps each instruction through fetch/decode/execute/writeback states,
// drives the datapath selects and write enables, and produces the 3-bit ALU
// function code.
//   clk    : rising-edge clock
//   reset  : synchronous, active high. Sends the FSM to FETCH and clears the
//            wait counter. While reset is high, all strobes are held at 0.
//   bus    : mc_if.master (op, funct, zero in; controls, illegal and
//            dbg_state out)
// MEM_WAIT : extra stall cycles in FETCH, MEMRD and MEMWR (0..15)
// ----------------------------------------------------------------------------
module mc_controller #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic clk,
   input  logic reset,
   mc_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

   state_t     state;
   state_t     nxt;
   logic [3:0] cnt;
   logic       last;       // final cycle of a (possibly stretched) state
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;

   assign last = (cnt == 4'd0);

   // R-type function decode. An unknown funct falls back to add.
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (bus.funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:   nxt = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYP:      nxt = RTYPEEX;
               OP_BEQ:       nxt = BEQEX;
               OP_ADDI:      nxt = ADDIEX;
               OP_J:         nxt = JEX;
               default:      nxt = FETCH;
            endcase
         end
         MEMADR:  nxt = (bus.op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   nxt = MEMWB;
         RTYPEEX: nxt = RTYPEWB;
         ADDIEX:  nxt = ADDIWB;
         default: nxt = FETCH;   // also catches undefined encodings
      endcase
   end

   // The counter is only ever non-zero inside FETCH/MEMRD/MEMWR. A non-zero
   // value holds the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         cnt   <= 4'd0;
      end else if (!last) begin
         cnt <= cnt - 4'd1;
      end else begin
         state <= nxt;
         cnt   <= (nxt == FETCH || nxt == MEMRD || nxt == MEMWR) ? WAIT_LD : 4'd0;
      end
   end

   // Moore decode. Unused selects are driven to 0. During reset the selects
   // show their FETCH values and every strobe is held at 0.
   always_comb begin
      bus.iord     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      bus.illegal  = 1'b0;
      aluop        = 2'b00;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      if (reset) begin
         bus.alusrcb = 2'b01;
      end else begin
         case (state)
            FETCH: begin
               bus.alusrcb = 2'b01;
               bus.irwrite = last;
               pcwrite     = last;
            end
            DECODE: begin
               bus.alusrcb = 2'b11;
               bus.illegal = !(bus.op inside {OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR, ADDIEX: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
            end
            MEMRD:   bus.iord = 1'b1;
            MEMWB: begin
               bus.memtoreg = 1'b1;
               bus.regwrite = 1'b1;
            end
            MEMWR: begin
               bus.iord     = 1'b1;
               bus.memwrite = last;
            end
            RTYPEEX: begin
               bus.alusrca = 1'b1;
               aluop       = 2'b10;
               bus.illegal = !funct_ok;
            end
            // funct comes from the held IR, so it is still valid here.
            RTYPEWB: begin
               bus.regdst   = 1'b1;
               bus.regwrite = funct_ok;
            end
            BEQEX: begin
               bus.alusrca = 1'b1;
               aluop       = 2'b01;
               bus.pcsrc   = 2'b01;
               branch      = 1'b1;
            end
            ADDIWB:  bus.regwrite = 1'b1;
            JEX: begin
               bus.pcsrc = 2'b10;
               pcwrite   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (aluop)
         2'b00:   bus.alucontrol = 3'b010;
         2'b01:   bus.alucontrol = 3'b110;
         default: bus.alucontrol = funct_alu;
      endcase
   end

   assign bus.pcen      = pcwrite | (branch & bus.zero);
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op_r = 6'd0;
   logic [5:0] funct_r = 6'd0;
   logic       zero_r = 1'b0;

   always #5 clk = ~clk;

   mc_if if0 ();
   mc_if if2 ();

   assign if0.op = op_r;  assign if0.funct = funct_r;  assign if0.zero = zero_r;
   assign if2.op = op_r;  assign if2.funct = funct_r;  assign if2.zero = zero_r;

   mc_controller #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
   mc_controller #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.master));

   typedef struct packed {
      logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] aluc;
      logic       illegal;
   } o_t;

   // Step names used only by the model below.
   typedef enum {S_F, S_D, S_MA, S_MR, S_MB, S_MW, S_RE, S_RB, S_BE, S_AE, S_AB, S_J} st_t;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   int          checks = 0;
   int          errors = 0;
   bit          fresh = 1'b1;   // next FETCH follows a reset (counter cleared)
   logic [15:0] exp_q[$];
   st_t         st_q[$];

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic o_t outs(input int sel);
      o_t o;
      if (sel == 0)
         o = '{if0.pcen, if0.iord, if0.memwrite, if0.irwrite, if0.regdst, if0.memtoreg,
               if0.regwrite, if0.alusrca, if0.alusrcb, if0.pcsrc, if0.alucontrol, if0.illegal};
      else
         o = '{if2.pcen, if2.iord, if2.memwrite, if2.irwrite, if2.regdst, if2.memtoreg,
               if2.regwrite, if2.alusrca, if2.alusrcb, if2.pcsrc, if2.alucontrol, if2.illegal};
      return o;
   endfunction

   function automatic bit op_known(input logic [5:0] op);
      return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
   endfunction

   // R-type ALU function: known functs map to their ALU code, anything else
   // is reported as unknown.
   function automatic bit r_alu(input logic [5:0] f, output logic [2:0] a);
      a = 3'b010;
      case (f)
         6'b100000: a = 3'b010;
         6'b100010: a = 3'b110;
         6'b100100: a = 3'b000;
         6'b100101: a = 3'b001;
         6'b101010: a = 3'b111;
         default:   return 1'b0;
      endcase
      return 1'b1;
   endfunction

   // Expected controls for one cycle of a step. last marks the final cycle
   // of a stretched step.
   function automatic o_t model(input st_t s, input bit last, input logic [5:0] op,
                                input logic [5:0] f, input logic z);
      o_t o;
      logic [2:0] a;
      bit ok;
      o = '0;
      o.aluc = 3'b010;
      ok = r_alu(f, a);
      case (s)
         S_F:  begin o.alusrcb = 2'b01; o.pcen = last; o.irwrite = last; end
         S_D:  begin o.alusrcb = 2'b11; o.illegal = !op_known(op); end
         S_MA: begin o.alusrca = 1; o.alusrcb = 2'b10; end
         S_MR: o.iord = 1;
         S_MB: begin o.memtoreg = 1; o.regwrite = 1; end
         S_MW: begin o.iord = 1; o.memwrite = last; end
         S_RE: begin o.alusrca = 1; o.aluc = a; o.illegal = !ok; end
         S_RB: begin o.regdst = 1; o.regwrite = ok; end
         S_BE: begin o.alusrca = 1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
         S_AE: begin o.alusrca = 1; o.alusrcb = 2'b10; end
         S_AB: o.regwrite = 1;
         S_J:  begin o.pcsrc = 2'b10; o.pcen = 1; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic push(input st_t s, input int n, input logic [5:0] op,
                       input logic [5:0] f, input logic z);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model(s, i == n - 1, op, f, z));
         st_q.push_back(s);
      end
   endtask

   // Runs one instruction on dut sel (w = its MEM_WAIT). The run stops after
   // 'cut' cycles when cut > 0. Entry and exit are just after a falling edge.
   task automatic run_instr(input int sel, input int w, input logic [5:0] op,
                            input logic [5:0] f, input logic z, input int cut);
      int n = 0;
      push(S_F, fresh ? 1 : w + 1, op, f, z);
      push(S_D, 1, op, f, z);
      case (op)
         LW:   begin push(S_MA, 1, op, f, z); push(S_MR, w + 1, op, f, z); push(S_MB, 1, op, f, z); end
         SW:   begin push(S_MA, 1, op, f, z); push(S_MW, w + 1, op, f, z); end
         RT:   begin push(S_RE, 1, op, f, z); push(S_RB, 1, op, f, z); end
         BEQ:  push(S_BE, 1, op, f, z);
         ADDI: begin push(S_AE, 1, op, f, z); push(S_AB, 1, op, f, z); end
         JMP:  push(S_J, 1, op, f, z);
         default: ;
      endcase
      op_r = op; funct_r = f; zero_r = z;
      #1;
      while (exp_q.size() > 0 && (cut == 0 || n < cut)) begin
         check($sformatf("d%0d op=%b f=%b %s#%0d", sel, op, f, st_q[0].name(), n),
               outs(sel), exp_q[0]);
         void'(exp_q.pop_front());
         void'(st_q.pop_front());
         n++;
         @(negedge clk);
      end
      exp_q.delete();
      st_q.delete();
      fresh = 1'b0;
   endtask

   task automatic do_reset(input int sel, input int n);
      o_t r = '0;
      r.alusrcb = 2'b01;
      r.aluc    = 3'b010;
      reset = 1'b1;
      #1;
      for (int i = 0; i < n; i++) begin
         check($sformatf("d%0d reset#%0d", sel, i), outs(sel), r);
         @(negedge clk);
      end
      reset = 1'b0;
      fresh = 1'b1;
   endtask

   task automatic run_random(input int sel, input int w, input int count);
      logic [5:0] ops[6] = '{LW, SW, RT, BEQ, ADDI, JMP};
      logic [5:0] fs[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] op, f;
      for (int i = 0; i < count; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom_range(0, 63));
            if (op_known(op)) op = 6'b111111;
         end else begin
            op = ops[$urandom_range(0, 5)];
         end
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fs[$urandom_range(0, 4)];
         run_instr(sel, w, op, f, 1'($urandom_range(0, 1)), 0);
      end
   endtask

   initial begin
      @(negedge clk);
      // MEM_WAIT = 0
      do_reset(0, 2);
      run_instr(0, 0, LW, 6'b000000, 1'b0, 0);
      run_instr(0, 0, RT, 6'b101010, 1'b0, 0);
      run_instr(0, 0, RT, 6'b100100, 1'b1, 0);
      run_instr(0, 0, RT, 6'b100101, 1'b0, 0);
      run_instr(0, 0, RT, 6'b100010, 1'b0, 0);
      run_instr(0, 0, BEQ, 6'b000000, 1'b1, 0);
      run_instr(0, 0, BEQ, 6'b000000, 1'b0, 0);
      run_instr(0, 0, 6'b111111, 6'b000000, 1'b0, 0);
      run_instr(0, 0, RT, 6'b000001, 1'b0, 0);
      run_instr(0, 0, SW, 6'b000000, 1'b0, 0);
      run_instr(0, 0, ADDI, 6'b000000, 1'b0, 0);
      run_instr(0, 0, LW, 6'b000000, 1'b0, 3);   // stop inside MEMRD
      do_reset(0, 1);
      run_instr(0, 0, JMP, 6'b000000, 1'b0, 0);
      run_random(0, 0, 40);
      // MEM_WAIT = 2
      do_reset(1, 2);
      run_instr(1, 2, SW, 6'b000000, 1'b0, 0);   // FETCH right after reset is short
      run_instr(1, 2, SW, 6'b000000, 1'b0, 0);   // 3-cycle FETCH and MEMWR
      run_instr(1, 2, LW, 6'b000000, 1'b0, 6);   // stop mid-MEMRD stall
      do_reset(1, 2);
      run_instr(1, 2, ADDI, 6'b000000, 1'b0, 0);
      run_instr(1, 2, BEQ, 6'b000000, 1'b1, 0);
      run_random(1, 2, 15);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
